// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Groups the fetch-sequencer control inputs and PC outputs into one bundle.
//   slave  : the sequencer (consumes redirect/stall/halt, produces pc and status)
//   master : the core / testbench that drives the controls and observes the PC
// Signals:
//   stall        - pipeline stall, PC must not advance while high
//   JumpI        - JR/JALR redirect request
//   jumpITarget  - register-relative jump target
//   jumpIErr     - overflow from the jump-immediate adder (already gated by JumpI)
//   branchTaken  - taken branch / PC-relative jump
//   branchTarget - branch / PC-relative target
//   halt         - HALT decoded
//   pc           - current fetch address
//   pcInc        - pc + 2 for the link register
//   fetchValid   - instruction at pc may issue
//   halted       - sequencer stopped in HALT
//   err          - sticky error flag
interface pc_sequencer_if;
    logic        stall;
    logic        JumpI;
    logic [15:0] jumpITarget;
    logic        jumpIErr;
    logic        branchTaken;
    logic [15:0] branchTarget;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] pcInc;
    logic        fetchValid;
    logic        halted;
    logic        err;

    modport slave (
        input  stall, JumpI, jumpITarget, jumpIErr, branchTaken, branchTarget, halt,
        output pc, pcInc, fetchValid, halted, err
    );

    modport master (
        output stall, JumpI, jumpITarget, jumpIErr, branchTaken, branchTarget, halt,
        input  pc, pcInc, fetchValid, halted, err
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer with stall handling, a one-entry pending redirect
// buffer, HALT and sticky ERR states.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - pc_sequencer_if.slave (controls in, pc/pcInc/status out)
module pc_sequencer (
    input  logic               clk,
    input  logic               rst,
    pc_sequencer_if.slave      bus
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        ERR  = 2'd2
    } seqState_t;

    seqState_t   stateReg, stateNext;
    logic [15:0] pcReg, pcNext;
    logic        pendValidReg, pendValidNext;
    logic [15:0] pendTargetReg, pendTargetNext;

    logic        redirect;
    logic [15:0] redirectTarget;
    logic        errCond;

    // JumpI wins over branchTaken when both request a redirect.
    assign redirect       = bus.JumpI | bus.branchTaken;
    assign redirectTarget = bus.JumpI ? bus.jumpITarget : bus.branchTarget;
    // Only the target actually selected is checked for alignment.
    assign errCond        = bus.jumpIErr | (redirect & redirectTarget[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg      <= RUN;
            pcReg         <= 16'h0000;
            pendValidReg  <= 1'b0;
            pendTargetReg <= 16'h0000;
        end else begin
            stateReg      <= stateNext;
            pcReg         <= pcNext;
            pendValidReg  <= pendValidNext;
            pendTargetReg <= pendTargetNext;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        pcNext         = pcReg;
        pendValidNext  = pendValidReg;
        pendTargetNext = pendTargetReg;
        case (stateReg)
            RUN: begin
                if (errCond) begin
                    // Bad target is dropped; pc freezes at the faulting fetch.
                    stateNext = ERR;
                end else if (bus.halt && !bus.stall) begin
                    stateNext = HALT;
                end else if (bus.stall) begin
                    // Park the newest redirect until the stall releases.
                    if (redirect) begin
                        pendValidNext  = 1'b1;
                        pendTargetNext = redirectTarget;
                    end
                end else if (redirect) begin
                    pcNext        = redirectTarget;
                    pendValidNext = 1'b0;
                end else if (pendValidReg) begin
                    pcNext        = pendTargetReg;
                    pendValidNext = 1'b0;
                end else begin
                    pcNext = bus.pcInc;
                end
            end
            HALT, ERR: begin
                // Terminal until reset.
            end
            default: begin
                stateNext = RUN;
            end
        endcase
    end

    assign bus.pc         = pcReg;
    assign bus.pcInc      = pcReg + 16'd2;
    // rst gates fetchValid so nothing issues while reset is held.
    assign bus.fetchValid = (stateReg == RUN) & ~bus.stall & ~pendValidReg & ~rst;
    assign bus.halted     = (stateReg == HALT);
    assign bus.err        = (stateReg == ERR);
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    logic clk;
    logic rst;
    int   passCount;
    int   checkCount;

    pc_sequencer_if bus();

    pc_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: mode 0=running, 1=halted, 2=error; pending redirect kept in a queue.
    logic [15:0] mPc;
    int          mMode;
    logic [15:0] pendQ[$];

    task automatic clearInputs();
        bus.stall = 0; bus.JumpI = 0; bus.jumpITarget = 0; bus.jumpIErr = 0;
        bus.branchTaken = 0; bus.branchTarget = 0; bus.halt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1;
        tick();
        checkCount++; if (bus.pc !== 16'h0000) $display("FAIL reset_pc got %h want 0000", bus.pc); else passCount++;
        checkCount++; if (bus.pcInc !== 16'h0002) $display("FAIL reset_pcInc got %h want 0002", bus.pcInc); else passCount++;
        checkCount++; if (bus.fetchValid !== 1'b0) $display("FAIL reset_fetchValid got %b want 0", bus.fetchValid); else passCount++;
        checkCount++; if ({bus.halted, bus.err} !== 2'b00) $display("FAIL reset_flags got %b want 00", {bus.halted, bus.err}); else passCount++;
        rst = 0;
        tick();
        checkCount++; if (bus.pc !== 16'h0002) $display("FAIL reset_first_edge got %h want 0002", bus.pc); else passCount++;
        $display("test_reset done");
    endtask

    task automatic test_free_run();
        doReset();
        checkCount++; if (bus.pc !== 16'h0000) $display("FAIL freerun_start got %h want 0000", bus.pc); else passCount++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkCount++;
            if (bus.pc !== 16'(2 * i)) $display("FAIL freerun_pc%0d got %h want %h", i, bus.pc, 16'(2 * i));
            else passCount++;
        end
        $display("test_free_run done");
    endtask

    task automatic test_wrap();
        doReset();
        bus.JumpI = 1; bus.jumpITarget = 16'hFFFE;
        tick();
        clearInputs();
        checkCount++; if (bus.pc !== 16'hFFFE) $display("FAIL wrap_jump got %h want fffe", bus.pc); else passCount++;
        checkCount++; if (bus.pcInc !== 16'h0000) $display("FAIL wrap_pcInc got %h want 0000", bus.pcInc); else passCount++;
        tick();
        checkCount++; if (bus.pc !== 16'h0000) $display("FAIL wrap_pc got %h want 0000", bus.pc); else passCount++;
        checkCount++; if (bus.err !== 1'b0) $display("FAIL wrap_err got %b want 0", bus.err); else passCount++;
        $display("test_wrap done");
    endtask

    task automatic test_stalled_redirect();
        doReset();
        bus.stall = 1; bus.JumpI = 1; bus.jumpITarget = 16'h1234;
        tick();
        bus.JumpI = 0;
        for (int i = 0; i < 3; i++) begin
            checkCount++; if (bus.pc !== 16'h0000) $display("FAIL stall_hold%0d got %h want 0000", i, bus.pc); else passCount++;
            checkCount++; if (bus.fetchValid !== 1'b0) $display("FAIL stall_fv%0d got %b want 0", i, bus.fetchValid); else passCount++;
            if (i < 2) tick();
        end
        bus.stall = 0;
        #1;
        checkCount++; if (bus.fetchValid !== 1'b0) $display("FAIL stall_pending_fv got %b want 0", bus.fetchValid); else passCount++;
        tick();
        checkCount++; if (bus.pc !== 16'h1234) $display("FAIL stall_release got %h want 1234", bus.pc); else passCount++;
        checkCount++; if (bus.fetchValid !== 1'b1) $display("FAIL stall_pend_cleared got %b want 1", bus.fetchValid); else passCount++;
        $display("test_stalled_redirect done");
    endtask

    task automatic test_priority();
        doReset();
        bus.JumpI = 1; bus.jumpITarget = 16'h0400;
        bus.branchTaken = 1; bus.branchTarget = 16'h0800;
        tick();
        clearInputs();
        checkCount++; if (bus.pc !== 16'h0400) $display("FAIL prio_target got %h want 0400", bus.pc); else passCount++;
        bus.JumpI = 1; bus.jumpITarget = 16'h0200; bus.jumpIErr = 1; bus.halt = 1;
        tick();
        clearInputs();
        checkCount++; if ({bus.err, bus.halted} !== 2'b10) $display("FAIL prio_err_state got %b want 10", {bus.err, bus.halted}); else passCount++;
        checkCount++; if (bus.pc !== 16'h0400) $display("FAIL prio_err_pc got %h want 0400", bus.pc); else passCount++;
        bus.JumpI = 1; bus.jumpITarget = 16'h0100;
        tick(); tick();
        clearInputs();
        checkCount++; if (bus.pc !== 16'h0400) $display("FAIL prio_err_frozen got %h want 0400", bus.pc); else passCount++;
        checkCount++; if (bus.err !== 1'b1) $display("FAIL prio_err_sticky got %b want 1", bus.err); else passCount++;
        $display("test_priority done");
    endtask

    task automatic test_misaligned_halt();
        doReset();
        bus.branchTaken = 1; bus.branchTarget = 16'h0101;
        tick();
        clearInputs();
        checkCount++; if (bus.err !== 1'b1) $display("FAIL misalign_err got %b want 1", bus.err); else passCount++;
        checkCount++; if (bus.pc !== 16'h0000) $display("FAIL misalign_pc got %h want 0000", bus.pc); else passCount++;
        doReset();
        tick(); tick(); tick();
        checkCount++; if (bus.pc !== 16'h0006) $display("FAIL halt_pre_pc got %h want 0006", bus.pc); else passCount++;
        bus.halt = 1;
        tick();
        bus.halt = 0;
        for (int i = 0; i < 3; i++) begin
            bus.JumpI = i[0]; bus.jumpITarget = 16'h2000;
            bus.branchTaken = ~i[0]; bus.branchTarget = 16'h3000;
            tick();
            checkCount++; if (bus.pc !== 16'h0006) $display("FAIL halt_pc%0d got %h want 0006", i, bus.pc); else passCount++;
            checkCount++; if (bus.halted !== 1'b1) $display("FAIL halt_flag%0d got %b want 1", i, bus.halted); else passCount++;
        end
        clearInputs();
        $display("test_misaligned_halt done");
    endtask

    task automatic test_async_reset();
        doReset();
        tick(); tick();
        bus.stall = 1; bus.JumpI = 1; bus.jumpITarget = 16'h0040;
        tick();
        clearInputs();
        bus.halt = 1;
        tick();
        clearInputs();
        checkCount++; if ({bus.halted, bus.pc} !== {1'b1, 16'h0004}) $display("FAIL async_pre got %b/%h want 1/0004", bus.halted, bus.pc); else passCount++;
        #2 rst = 1;
        #1;
        checkCount++; if (bus.pc !== 16'h0000) $display("FAIL async_pc got %h want 0000", bus.pc); else passCount++;
        checkCount++; if (bus.halted !== 1'b0) $display("FAIL async_halted got %b want 0", bus.halted); else passCount++;
        checkCount++; if (bus.fetchValid !== 1'b0) $display("FAIL async_fv_in_rst got %b want 0", bus.fetchValid); else passCount++;
        rst = 0;
        #1;
        checkCount++; if (bus.fetchValid !== 1'b1) $display("FAIL async_pend_cleared got %b want 1", bus.fetchValid); else passCount++;
        tick();
        checkCount++; if (bus.pc !== 16'h0002) $display("FAIL async_after got %h want 0002", bus.pc); else passCount++;
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        logic        redir;
        logic [15:0] tgt;
        logic        expFv;
        doReset();
        mPc = 16'h0000; mMode = 0; pendQ.delete();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 29) == 0);
            bus.stall = ($urandom_range(0, 2) == 0);
            bus.JumpI = ($urandom_range(0, 5) == 0);
            bus.branchTaken = ($urandom_range(0, 5) == 0);
            bus.jumpITarget = 16'($urandom) & (($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'hFFFE);
            bus.branchTarget = 16'($urandom) & (($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'hFFFE);
            bus.jumpIErr = bus.JumpI && ($urandom_range(0, 19) == 0);
            bus.halt = ($urandom_range(0, 39) == 0);
            #1;
            expFv = !rst && mMode == 0 && !bus.stall && pendQ.size() == 0;
            checkCount++; if (bus.fetchValid !== expFv) $display("FAIL rand_fv cyc%0d got %b want %b", n, bus.fetchValid, expFv); else passCount++;
            @(posedge clk);
            redir = bus.JumpI | bus.branchTaken;
            tgt = bus.JumpI ? bus.jumpITarget : bus.branchTarget;
            if (rst) begin
                mPc = 0; mMode = 0; pendQ.delete();
            end else if (mMode == 0) begin
                if (bus.jumpIErr || (redir && tgt[0])) mMode = 2;
                else if (bus.halt && !bus.stall) mMode = 1;
                else if (bus.stall) begin
                    if (redir) begin pendQ.delete(); pendQ.push_back(tgt); end
                end
                else if (redir) begin mPc = tgt; pendQ.delete(); end
                else if (pendQ.size() > 0) mPc = pendQ.pop_front();
                else mPc = 16'(mPc + 16'd2);
            end
            #1;
            checkCount++;
            if ({bus.pc, bus.pcInc, bus.halted, bus.err} !== {mPc, 16'(mPc + 16'd2), mMode == 1, mMode == 2})
                $display("FAIL rand_state cyc%0d got pc=%h inc=%h h=%b e=%b want pc=%h h=%0d e=%0d",
                         n, bus.pc, bus.pcInc, bus.halted, bus.err, mPc, mMode == 1, mMode == 2);
            else passCount++;
        end
        rst = 0;
        clearInputs();
        $display("test_random done");
    endtask

    initial begin
        passCount = 0;
        checkCount = 0;
        rst = 0;
        clearInputs();
        #1;
        test_reset();
        test_free_run();
        test_wrap();
        test_stalled_redirect();
        test_priority();
        test_misaligned_halt();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have stall, input, 1, pipeline stall; PC must not advance while high.
REQ-004 SHALL have JumpI, input, 1, JR/JALR redirect request this cycle.
REQ-005 SHALL have jumpITarget, input, 16, Rs + sign-extended immediate from the jump-immediate unit.
REQ-006 SHALL have jumpIErr, input, 1, overflow flag from the jump-immediate unit (already gated by JumpI).
REQ-007 SHALL have branchTaken, input, 1, resolved taken branch or PC-relative jump this cycle.
REQ-008 SHALL have branchTarget, input, 16, branch or PC-relative target.
REQ-009 SHALL have halt, input, 1, HALT instruction decoded.
REQ-010 SHALL have pc, output, 16, current fetch address.
REQ-011 SHALL have pcInc, output, 16, pc + 2, for the link register.
REQ-012 SHALL have fetchValid, output, 1, instruction at pc is valid to issue.
REQ-013 SHALL have halted, output, 1, sequencer in HALT state.
REQ-014 SHALL have err, output, 1, sticky error flag.

Function
REQ-015 SHALL implement three states: RUN, HALT, ERR.
REQ-016 SHALL encode state in a register.
REQ-017 SHALL not enter any other state.
REQ-018 SHALL compute pcInc combinationally as pc + 2, modulo 2^16 (0xFFFE -> 0x0000).
REQ-019 SHALL not raise err on pcInc wrap-around.
REQ-020 SHALL treat a redirect as JumpI | branchTaken.
REQ-021 SHALL give JumpI priority over branchTaken when both are asserted; the redirect target is then jumpITarget.
REQ-022 SHALL, in RUN with stall=0 and no redirect and no pending redirect, load pc <= pcInc.
REQ-023 SHALL, in RUN with stall=0 and a redirect, load pc <= the selected target, taking effect on the next cycle (1-cycle latency).
REQ-024 SHALL, in RUN with stall=1 and a redirect, hold pc and capture the target into pendTarget with pendValid=1.
REQ-025 SHALL let a newer redirect that arrives during a stall overwrite pendTarget.
REQ-026 SHALL, in RUN with stall=0 and pendValid=1 and no new redirect, load pc <= pendTarget and clear pendValid.
REQ-027 SHALL let a new redirect at stall release win over pendTarget, and SHALL clear pendValid.
REQ-028 SHALL, in RUN with stall=1 and no redirect, hold pc and pendValid unchanged.
REQ-029 SHALL treat a redirect target with bit 0 = 1 as misaligned.
REQ-030 SHALL, when jumpIErr=1 or a misaligned target is presented in RUN (stalled or not), go to ERR, set err=1, hold pc, and discard the target.
REQ-031 SHALL give the error condition priority over halt and redirect.
REQ-032 SHALL, when halt=1 and stall=0 in RUN with no error, go to HALT and hold pc at the HALT address.
REQ-033 SHALL ignore halt while stall=1.
REQ-034 SHALL, in HALT, hold pc, keep halted=1, and ignore all inputs except rst.
REQ-035 SHALL, in ERR, hold pc, keep err=1, and ignore all inputs except rst.
REQ-036 SHALL drive fetchValid = (state==RUN) & ~stall & ~pendValid.

Reset
REQ-037 SHALL, on rst=1 at any time (including mid-stall or with pendValid=1), asynchronously force pc=0x0000, state=RUN, pendValid=0, pendTarget=0x0000, err=0, halted=0.
REQ-038 SHALL, while rst=1, drive pcInc=0x0002 and fetchValid=0.
REQ-039 SHALL, after rst deasserts with stall=0, have pc advance to 0x0002 on the first rising edge.

Verification
REQ-040 SHALL cover free run: reset, stall=0, no redirects for 4 edges -> pc sequence 0x0000, 0x0002, 0x0004, 0x0006, 0x0008.
REQ-041 SHALL cover wrap: with pc=0xFFFE, no stall -> next pc=0x0000, err=0.
REQ-042 SHALL cover stalled redirect: stall=1 with JumpI=1, jumpITarget=0x1234 for 1 cycle, stall held 2 more cycles -> pc held, fetchValid=0; stall drops -> next pc=0x1234, pendValid=0.
REQ-043 SHALL cover priority: JumpI=1 at 0x0400 and branchTaken=1 at 0x0800 in the same unstalled cycle -> pc=0x0400; then jumpIErr=1 with halt=1 -> state ERR, err=1, pc frozen.
REQ-044 SHALL cover misaligned target and halt: branchTarget=0x0101 taken -> ERR, err=1; after reset, halt=1 at pc=0x0006 with stall=0 -> halted=1, pc stays 0x0006 for 3 cycles despite toggling redirects.
REQ-045 SHALL cover async reset: assert rst mid-cycle while pendValid=1 and state=HALT -> pc=0x0000, halted=0, pendValid=0 immediately, without waiting for a clock edge.
